parity_check_stream: RTL

Streaming, parametrised parity checker: accepts DATA_W-bit words plus a parity bit over a valid/ready handshake and checks odd or even parity at run time. Each word is forwarded with a per-word error flag through a single registered output stage. Alongside it, the block keeps a saturating error counter, a sticky error flag and a consecutive-error alarm. It sits between a serial/link receiver and downstream consumers as the link-integrity stage.

---
 rtl/parity_check_stream.sv | 91 +++++++++
 1 files changed

// File: rtl/parity_check_stream.sv
// Streaming odd/even parity checker with a registered output stage and error status.
// Define PARITY_CHECK_DROP_EN to drop erroneous words instead of forwarding them.
module parity_check_stream #(
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 8,
  parameter int ALARM_THR = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_sticky,
  output logic              alarm
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(ALARM_THR);

  logic             accept;
  logic             word_err;
  logic             load;
  logic             load_err;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] err_inc;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign word_err = odd_mode ? ~^{in_data, in_parity} : ^{in_data, in_parity};
  assign run_inc  = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1);
  assign err_inc  = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);

`ifdef PARITY_CHECK_DROP_EN
  assign load     = accept & ~word_err;
  assign load_err = 1'b0;
`else
  assign load     = accept;
  assign load_err = word_err;
`endif

  // Single output register; a reload during the output handshake keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_err   <= load_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status tracking; clr wins over an erroneous accept in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      run_cnt    <= '0;
      err_sticky <= 1'b0;
      alarm      <= 1'b0;
    end else if (clr) begin
      err_count  <= '0;
      run_cnt    <= '0;
      err_sticky <= 1'b0;
      alarm      <= 1'b0;
    end else if (accept) begin
      if (word_err) begin
        err_count  <= err_inc;
        run_cnt    <= run_inc;
        err_sticky <= 1'b1;
        if (run_inc == THR) begin
          alarm <= 1'b1;
        end
      end else begin
        run_cnt <= '0;
      end
    end
  end

endmodule
